// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-side datapath: access FSM states,
// default widths and the bus-mux source select used for MDR.
package cpu_mem_pkg;

  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_ADDR_W = 9;

  // Bus multiplexer source select for the MDR output
  localparam logic [4:0] SEL_MDR = 5'd21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for memory accesses. Counts enabled cycles from zero
// and flags the last permitted wait cycle (count == TIMEOUT-1).
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT - 1));

  // Count wait cycles; holds at the expiry value so it never wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_data_interface.sv
// MAR/MDR owner and synchronous-RAM handshake controller. Accesses are
// sequenced by a four-state FSM with ack wait-states and a timeout; all
// outputs come straight from registers.
module mem_data_interface
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] BusMuxIn_MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              mem_err
);

  mem_state_t        state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              waiting;
  logic              timer_clear;
  logic              timer_en;
  logic              expired;

  assign BusMuxIn_MDR = mdr;
  assign mem_wdata    = mdr;
  assign mem_addr     = mar;
  assign busy         = (state != IDLE);

  assign waiting      = (state == RD_WAIT) || (state == WR_WAIT);
  assign timer_clear  = (state == IDLE);
  assign timer_en     = waiting && !mem_ack;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  // Access FSM with registered handshake outputs; MAR/MDR load only in IDLE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mar     <= '0;
      mdr     <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      done    <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (MARin) mar <= BusMuxOut[ADDR_W-1:0];
          if (MDRin) mdr <= BusMuxOut;
          if (Read) begin
            state   <= RD_WAIT;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            mem_err <= 1'b0;
          end else if (Write) begin
            state   <= WR_WAIT;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            mem_err <= 1'b0;
          end
        end
        RD_WAIT, WR_WAIT: begin
          // Ack takes priority over a timeout landing on the same edge
          if (mem_ack) begin
            if (state == RD_WAIT) mdr <= mem_rdata;
            state   <= DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
          end else if (expired) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
            mem_err <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_interface.sv
// Self-checking bench for mem_data_interface: directed accesses with a
// transaction-level reference model compared on every falling edge.
module tb_mem_data_interface;
  import cpu_mem_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic        MARin = 1'b0;
  logic        MDRin = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [31:0] BusMuxIn_MDR;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        mem_err;

  always #5 clock = ~clock;

  mem_data_interface #(
    .DATA_W  (32),
    .ADDR_W  (9),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .BusMuxOut    (BusMuxOut),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .Read         (Read),
    .Write        (Write),
    .BusMuxIn_MDR (BusMuxIn_MDR),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .busy         (busy),
    .done         (done),
    .mem_err      (mem_err)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: kind 0 = no access, 1 = read pending, 2 = write pending;
  // waited counts request cycles already spent without ack.
  logic [8:0]  m_mar    = '0;
  logic [31:0] m_mdr    = '0;
  int          m_kind   = 0;
  int          m_waited = 0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mar = '0; m_mdr = '0; m_kind = 0; m_waited = 0; m_done = 1'b0; m_err = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_kind != 0) begin
      if (mem_ack) begin
        if (m_kind == 1) m_mdr = mem_rdata;
        m_kind = 0;
        m_done = 1'b1;
      end else if (m_waited + 1 == TIMEOUT) begin
        m_err  = 1'b1;
        m_kind = 0;
        m_done = 1'b1;
      end else begin
        m_waited++;
      end
    end else begin
      if (MARin) m_mar = BusMuxOut[8:0];
      if (MDRin) m_mdr = BusMuxOut;
      if (Read) begin
        m_kind = 1; m_waited = 0; m_err = 1'b0;
      end else if (Write) begin
        m_kind = 2; m_waited = 0; m_err = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en && reset_n) begin
      check("mem_req",   32'(mem_req),   32'(m_kind != 0));
      check("busy",      32'(busy),      32'((m_kind != 0) || m_done));
      check("done",      32'(done),      32'(m_done));
      check("mem_err",   32'(mem_err),   32'(m_err));
      check("mdr",       BusMuxIn_MDR,   m_mdr);
      check("mem_wdata", mem_wdata,      m_mdr);
      check("mem_addr",  32'(mem_addr),  32'(m_mar));
      if (m_kind != 0) check("mem_we", 32'(mem_we), 32'(m_kind == 2));
    end
  end

  task automatic load(input bit mar_ld, input bit mdr_ld, input logic [31:0] bus);
    @(negedge clock);
    MARin = mar_ld; MDRin = mdr_ld; BusMuxOut = bus;
    @(negedge clock);
    MARin = 1'b0; MDRin = 1'b0; BusMuxOut = '0;
  endtask

  // Issue one access; RAM acks on request cycle ack_at (0 = never).
  // junk drives every control input high while the access is in flight.
  task automatic do_access(input bit rd, input bit wr, input bit mar_ld, input bit mdr_ld,
                           input logic [31:0] bus, input int ack_at, input logic [31:0] rdata,
                           input bit junk, output int req_cyc, output int done_cyc,
                           output logic first_we, output logic [8:0] first_addr,
                           output logic [31:0] first_wdata);
    bit finished;
    req_cyc = 0; done_cyc = 0; first_we = 1'b0; first_addr = '0; first_wdata = '0;
    finished = 1'b0;
    @(negedge clock);
    Read = rd; Write = wr; MARin = mar_ld; MDRin = mdr_ld; BusMuxOut = bus;
    @(negedge clock);
    Read = 1'b0; Write = 1'b0; MARin = 1'b0; MDRin = 1'b0; BusMuxOut = '0;
    for (int i = 0; i < 300; i++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          first_we = mem_we; first_addr = mem_addr; first_wdata = mem_wdata;
        end
        if (req_cyc == ack_at) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
      end
      if (done) done_cyc++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (junk) begin
        MARin = 1'b1; MDRin = 1'b1; Read = 1'b1; Write = 1'b1; BusMuxOut = '1;
      end
      @(negedge clock);
    end
    mem_ack = 1'b0;
    Read = 1'b0; Write = 1'b0; MARin = 1'b0; MDRin = 1'b0; BusMuxOut = '0;
    check("access_terminates", 32'(finished), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int          rq, dn;
    logic        fwe;
    logic [8:0]  fad;
    logic [31:0] fwd;

    // Reset state
    #12;
    check("rst_req",  32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_done", 32'(done),    32'd0);
    check("rst_err",  32'(mem_err), 32'd0);
    check("rst_mdr",  BusMuxIn_MDR, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Zero-wait read
    load(1'b1, 1'b0, 32'h0000_0085);
    do_access(1'b1, 1'b0, 1'b0, 1'b0, '0, 1, 32'hDEAD_BEEF, 1'b0, rq, dn, fwe, fad, fwd);
    check("zw_addr",     32'(fad),     32'h085);
    check("zw_we",       32'(fwe),     32'd0);
    check("zw_req_cyc",  32'(rq),      32'd1);
    check("zw_done_cyc", 32'(dn),      32'd1);
    check("zw_mdr",      BusMuxIn_MDR, 32'hDEAD_BEEF);
    check("zw_model",    m_mdr,        32'hDEAD_BEEF);
    check("zw_err",      32'(mem_err), 32'd0);

    // Write with three wait-states; MAR keeps only the low 9 bits
    load(1'b0, 1'b1, 32'h1234_5678);
    load(1'b1, 1'b0, 32'hFFFF_FE10);
    do_access(1'b0, 1'b1, 1'b0, 1'b0, '0, 4, 32'h0, 1'b0, rq, dn, fwe, fad, fwd);
    check("wr_addr",     32'(fad),     32'h010);
    check("wr_model",    32'(m_mar),   32'h010);
    check("wr_we",       32'(fwe),     32'd1);
    check("wr_wdata",    fwd,          32'h1234_5678);
    check("wr_req_cyc",  32'(rq),      32'd4);
    check("wr_done_cyc", 32'(dn),      32'd1);

    // Timeout with no ack; MDR must survive
    load(1'b0, 1'b1, 32'hAAAA_5555);
    do_access(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 32'h0, 1'b0, rq, dn, fwe, fad, fwd);
    check("to_req_cyc",  32'(rq),      32'd16);
    check("to_done_cyc", 32'(dn),      32'd1);
    check("to_err",      32'(mem_err), 32'd1);
    check("to_mdr",      BusMuxIn_MDR, 32'hAAAA_5555);
    do_access(1'b1, 1'b0, 1'b0, 1'b0, '0, 2, 32'h0BAD_F00D, 1'b0, rq, dn, fwe, fad, fwd);
    check("to_clear_err", 32'(mem_err), 32'd0);
    check("to_next_mdr",  BusMuxIn_MDR, 32'h0BAD_F00D);

    // Read+Write with MARin in the same cycle; all inputs hammered while busy
    do_access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_01C3, 3, 32'h55AA_1234, 1'b1, rq, dn, fwe, fad, fwd);
    check("rw_we",       32'(fwe),      32'd0);
    check("rw_addr",     32'(fad),      32'h1C3);
    check("rw_mdr",      BusMuxIn_MDR,  32'h55AA_1234);
    check("rw_addr_hold", 32'(mem_addr), 32'h1C3);
    check("rw_idle",     32'(busy),     32'd0);

    // Ack on the timeout cycle wins
    do_access(1'b1, 1'b0, 1'b0, 1'b0, '0, 16, 32'h600D_CAFE, 1'b0, rq, dn, fwe, fad, fwd);
    check("ackto_req_cyc", 32'(rq),      32'd16);
    check("ackto_err",     32'(mem_err), 32'd0);
    check("ackto_mdr",     BusMuxIn_MDR, 32'h600D_CAFE);

    // Stray ack while idle
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    mem_ack = 1'b0;
    check("stray_busy", 32'(busy),     32'd0);
    check("stray_done", 32'(done),     32'd0);
    check("stray_mdr",  BusMuxIn_MDR,  32'h600D_CAFE);
    @(negedge clock);
    check("stray_busy2", 32'(busy),    32'd0);

    // Reset mid-access
    @(negedge clock);
    Read = 1'b1;
    @(negedge clock);
    Read = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_req_before", 32'(mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req",  32'(mem_req),  32'd0);
    check("mid_rst_busy", 32'(busy),     32'd0);
    check("mid_rst_mdr",  BusMuxIn_MDR,  32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Recovery after reset
    load(1'b1, 1'b0, 32'h0000_00AB);
    do_access(1'b1, 1'b0, 1'b0, 1'b0, '0, 1, 32'h1357_9BDF, 1'b0, rq, dn, fwe, fad, fwd);
    check("rec_addr", 32'(fad),     32'h0AB);
    check("rec_mdr",  BusMuxIn_MDR, 32'h1357_9BDF);

    @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_data_interface.md
Name: mem_data_interface

Overview:
- Owns the MAR and MDR registers and runs the read/write handshake between the datapath and the synchronous RAM.
- Sits directly upstream of the bus multiplexer: its MDR output drives the multiplexer's MDR input (source select 21).
- Takes its bus-side load data from BusMuxOut.
- Multi-cycle memory accesses are sequenced by a small FSM with ack wait-states and a timeout.

Parameters:
- DATA_W, 32: bus and MDR width.
- ADDR_W, 9: MAR width and RAM address width (512 words).
- TIMEOUT, 16: maximum wait cycles for mem_ack before the access is abandoned. Legal range is 2..255.

Ports:
- clock  in  1  system clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- BusMuxOut  in  DATA_W  bus value; load source for MAR and MDR.
- MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0].
- MDRin  in  1  load MDR from BusMuxOut.
- Read  in  1  start a memory read at address MAR.
- Write  in  1  start a memory write of MDR to address MAR.
- BusMuxIn_MDR  out  DATA_W  MDR contents, driven to the bus mux.
- mem_addr  out  ADDR_W  RAM address, equal to MAR.
- mem_wdata  out  DATA_W  RAM write data, equal to MDR.
- mem_req  out  1  registered request; held high until ack or timeout.
- mem_we  out  1  registered; 1 = write, 0 = read; valid while mem_req is high.
- mem_rdata  in  DATA_W  RAM read data, valid when mem_ack is high.
- mem_ack  in  1  RAM completion, one cycle wide.
- busy  out  1  FSM is not in IDLE.
- done  out  1  one-cycle pulse when an access ends (success or timeout).
- mem_err  out  1  sticky flag: the last access timed out.

Behaviour:
- Reset, asynchronous, active on reset_n=0:
  - MAR = 0, MDR = 0.
  - mem_req = 0, mem_we = 0, busy = 0, done = 0, mem_err = 0.
  - Wait counter = 0, state = IDLE.
  - Reset asserted mid-access drops mem_req immediately; the access is discarded and MDR is not updated.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - MARin=1 loads MAR.
  - MDRin=1 loads MDR.
  - Both may load in the same cycle.
  - Read=1 at an edge → RD_WAIT with mem_req=1, mem_we=0, counter=0, mem_err cleared.
  - Write=1 at an edge → WR_WAIT with mem_req=1, mem_we=1, mem_err cleared.
  - Read and Write together: Read wins, Write is ignored.
  - MARin together with Read/Write: the access starts in the same cycle and uses the newly loaded MAR. mem_addr is MAR, so it reflects the new value from the next cycle onward.
  - MDRin together with Write: the write uses the newly loaded MDR.
- RD_WAIT / WR_WAIT:
  - mem_ack=1 → go to DONE and drop mem_req. In RD_WAIT only, MDR <= mem_rdata on the same edge.
  - Otherwise the counter increments.
  - Counter == TIMEOUT-1 with no ack → set mem_err, leave MDR unchanged, drop mem_req, go to DONE.
  - Ack in the same cycle as the timeout → ack wins; no error.
  - MARin, MDRin, Read and Write are all ignored while busy; MAR and MDR are frozen.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - MDRin/MARin are ignored in DONE.
  - Read/Write asserted in DONE is ignored. The controller must re-issue after done.
- Latency: with mem_ack returned in the first request cycle, Read sampled at edge E0 gives:
  - mem_req high E0..E1;
  - MDR valid and done high after E1;
  - IDLE after E2.
  - Every wait-state adds one cycle.
- mem_ack in IDLE or DONE is ignored.
- BusMuxIn_MDR, mem_addr and mem_wdata are continuous copies of MDR/MAR. There is no combinational path from any input to any output.
- Widths:
  - MAR takes the low ADDR_W bits of the bus; upper bits are dropped.
  - MDR is the full DATA_W; no sign extension.
  - The counter is $clog2(TIMEOUT) bits wide.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - the FSM state enum mem_state_t (IDLE, RD_WAIT, WR_WAIT, DONE);
  - localparams MEM_DATA_W=32, MEM_ADDR_W=9;
  - the source-select constant SEL_MDR=5'd21, shared with the bus mux and the control unit.
- One sub-module, mem_wait_timer: counter with clear, enable and expired outputs, parameterised by TIMEOUT.

Test Plan:
- Reset mid-access: reset_n low mid-RD_WAIT → mem_req=0, busy=0, MDR=0, MAR=0 asynchronously.
- Zero-wait read: BusMuxOut=0x0000_0085 with MARin, then Read; RAM acks the first request cycle with 0xDEAD_BEEF:
  - mem_addr=0x085;
  - BusMuxIn_MDR=0xDEAD_BEEF;
  - done exactly one cycle;
  - mem_err=0.
- Write with 3 wait-states: MDRin with bus 0x1234_5678, MARin with bus 0xFFFF_FE10, then Write:
  - mem_addr=0x010, mem_we=1, mem_wdata=0x1234_5678;
  - mem_req high 4 cycles;
  - done one cycle after ack.
- Timeout with TIMEOUT=16 and no ack, MDR preloaded 0xAAAA_5555:
  - mem_req high 16 cycles, then done;
  - mem_err=1; MDR still 0xAAAA_5555;
  - the next Read clears mem_err.
- Read+Write asserted together → only a read is performed (mem_we=0). MDRin asserted while busy → MDR not changed by the bus.
- Ack arriving on the timeout cycle → MDR = mem_rdata, mem_err=0. Stray mem_ack in IDLE → no state change.
